// File: rtl/n210_spi_cfg_arb_pkg.sv
// rtl/n210_spi_cfg_arb_pkg.sv - shared types and constants for the N210 SPI config arbiter
package n210_spi_pkg;

  // Shift engine sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Requester indices; also the value held by the round-robin pointer
  localparam logic DEV_ADC = 1'b0;
  localparam logic DEV_DAC = 1'b1;

  // Command word and readback widths
  localparam int WORD_W = 16;
  localparam int RB_W   = 8;

endpackage

// File: rtl/n210_spi_cfg_arb_if.sv
// rtl/n210_spi_cfg_arb_if.sv - control-plane request/response bundle for the SPI config arbiter
interface n210_spi_cfg_arb_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_data;
  logic [1:0]  req_rd;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_rd,
    output req_ready, rsp_valid, rsp_data, busy
  );

  // Requester side
  modport master (
    output req_valid, req_data, req_rd,
    input  req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/n210_spi_shift_engine.sv
// rtl/n210_spi_shift_engine.sv - mode-0 SPI shift engine: setup, 16-bit shift, hold and CS gap
module n210_spi_shift_engine
  import n210_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_rd,
  input  logic              i_smiso,
  output logic              o_idle,
  output logic              o_done,
  output logic [RB_W-1:0]   o_rb,
  output logic              o_sclk,
  output logic              o_sen,
  output logic              o_smosi
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
  localparam logic [4:0] BITS_ALL  = 5'(WORD_W);

  spi_state_e        r_state;
  logic [7:0]        r_phase;
  logic [4:0]        r_bits;
  logic [WORD_W-1:0] r_tx;
  logic [RB_W-1:0]   r_cap;
  logic              r_rd;
  logic              r_sclk;
  logic              r_sen;
  logic              r_smosi;
  logic              r_done;
  logic [RB_W-1:0]   r_rb;

  logic              w_half_end;

  assign w_half_end = (r_phase == HALF_LAST);

  assign o_idle  = (r_state == ST_IDLE);
  assign o_done  = r_done;
  assign o_rb    = r_rb;
  assign o_sclk  = r_sclk;
  assign o_sen   = r_sen;
  assign o_smosi = r_smosi;

  // Transaction sequencer; r_tx holds the bits still to be presented after the one on smosi,
  // and only the trailing RB_W smiso samples are kept since that is all that is reported
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bits  <= '0;
      r_tx    <= '0;
      r_cap   <= '0;
      r_rd    <= 1'b0;
      r_sclk  <= 1'b0;
      r_sen   <= 1'b1;
      r_smosi <= 1'b0;
      r_done  <= 1'b0;
      r_rb    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_tx    <= {i_word[WORD_W-2:0], 1'b0};
            r_rd    <= i_rd;
            r_cap   <= '0;
            r_phase <= '0;
            r_bits  <= '0;
            r_sen   <= 1'b0;
            r_smosi <= i_word[WORD_W-1];
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_half_end) begin
            r_phase <= '0;
            r_sclk  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (!w_half_end) begin
            r_phase <= r_phase + 8'd1;
          end else begin
            r_phase <= '0;
            if (r_sclk) begin
              // end of high phase: sample slave, drop SCLK and present the next bit together
              r_sclk  <= 1'b0;
              r_cap   <= {r_cap[RB_W-2:0], i_smiso};
              r_smosi <= r_tx[WORD_W-1];
              r_tx    <= {r_tx[WORD_W-2:0], 1'b0};
              r_bits  <= r_bits + 5'd1;
            end else if (r_bits == BITS_ALL) begin
              r_state <= ST_HOLD;
            end else begin
              r_sclk <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_half_end) begin
            r_phase <= '0;
            r_sen   <= 1'b1;
            r_smosi <= 1'b0;
            r_state <= ST_GAP;
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        ST_GAP: begin
          if (r_phase == GAP_LAST) begin
            r_phase <= '0;
            r_done  <= 1'b1;
            r_rb    <= r_rd ? r_cap : '0;
            r_state <= ST_IDLE;
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/n210_spi_cfg_arb.sv
// rtl/n210_spi_cfg_arb.sv - round-robin ADC/DAC SPI configuration arbiter with pin steering
module n210_spi_cfg_arb
  import n210_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  n210_spi_cfg_arb_if.slave    cfg,
  output logic                 adc_sclk,
  output logic                 adc_sen,
  output logic                 adc_smosi,
  input  logic                 adc_smiso_i,
  output logic                 dac_sclk,
  output logic                 dac_sen,
  output logic                 dac_smosi,
  input  logic                 dac_smiso_i
);

  logic              r_last;
  logic [1:0]        w_grant;
  logic              w_start;
  logic [WORD_W-1:0] w_word;
  logic              w_rd;
  logic              w_smiso;
  logic              w_idle;
  logic              w_done;
  logic [RB_W-1:0]   w_rb;
  logic              w_sclk;
  logic              w_sen;
  logic              w_smosi;
  logic              w_sel_adc;

  // Grant only while the engine is idle and out of reset; a contested grant goes to the
  // requester that was not served last
  always_comb begin
    w_grant = 2'b00;
    if (RST_N && w_idle) begin
      if (cfg.req_valid == 2'b11) begin
        w_grant = (r_last == DEV_DAC) ? 2'b01 : 2'b10;
      end else begin
        w_grant = cfg.req_valid;
      end
    end
  end

  assign w_start = |w_grant;
  assign w_word  = w_grant[1] ? cfg.req_data[31:16] : cfg.req_data[15:0];
  assign w_rd    = w_grant[1] ? cfg.req_rd[1] : cfg.req_rd[0];

  // Round-robin pointer doubles as the index of the transaction in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last <= DEV_DAC;
    end else if (w_start) begin
      r_last <= w_grant[1];
    end
  end

  n210_spi_shift_engine #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_engine (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_start (w_start),
    .i_word  (w_word),
    .i_rd    (w_rd),
    .i_smiso (w_smiso),
    .o_idle  (w_idle),
    .o_done  (w_done),
    .o_rb    (w_rb),
    .o_sclk  (w_sclk),
    .o_sen   (w_sen),
    .o_smosi (w_smosi)
  );

  assign cfg.req_ready = w_grant;
  assign cfg.busy      = w_start | ~w_idle;
  assign cfg.rsp_valid = w_done ? ((r_last == DEV_DAC) ? 2'b10 : 2'b01) : 2'b00;
  assign cfg.rsp_data  = w_rb;

  // Engine outputs rest at idle levels outside a transaction, so steering on r_last is safe
  assign w_sel_adc = (r_last == DEV_ADC);
  assign w_smiso   = w_sel_adc ? adc_smiso_i : dac_smiso_i;

  assign adc_sclk  = w_sel_adc & w_sclk;
  assign adc_sen   = w_sel_adc ? w_sen : 1'b1;
  assign adc_smosi = w_sel_adc & w_smosi;
  assign dac_sclk  = ~w_sel_adc & w_sclk;
  assign dac_sen   = w_sel_adc ? 1'b1 : w_sen;
  assign dac_smosi = ~w_sel_adc & w_smosi;

endmodule

// File: tb/tb_n210_spi_cfg_arb.sv
// tb/tb_n210_spi_cfg_arb.sv - self-checking bench for n210_spi_cfg_arb
module tb_n210_spi_cfg_arb;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  n210_spi_cfg_arb_if b0 ();
  n210_spi_cfg_arb_if b1 ();

  logic        sel = 1'b0;
  logic [1:0]  v = 2'b00;
  logic [1:0]  rd = 2'b00;
  logic [31:0] d = 32'h0;
  logic [1:0]  miso;

  assign b0.req_valid = sel ? 2'b00 : v;
  assign b0.req_data  = d;
  assign b0.req_rd    = rd;
  assign b1.req_valid = sel ? v : 2'b00;
  assign b1.req_data  = d;
  assign b1.req_rd    = rd;

  wire a0_sclk, a0_sen, a0_mosi, d0_sclk, d0_sen, d0_mosi;
  wire a1_sclk, a1_sen, a1_mosi, d1_sclk, d1_sen, d1_mosi;

  n210_spi_cfg_arb #(.CLK_DIV(4), .CS_GAP(8)) u0 (
    .CLK(CLK), .RST_N(rst_n), .cfg(b0),
    .adc_sclk(a0_sclk), .adc_sen(a0_sen), .adc_smosi(a0_mosi), .adc_smiso_i(miso[0]),
    .dac_sclk(d0_sclk), .dac_sen(d0_sen), .dac_smosi(d0_mosi), .dac_smiso_i(miso[1])
  );

  n210_spi_cfg_arb #(.CLK_DIV(2), .CS_GAP(1)) u1 (
    .CLK(CLK), .RST_N(rst_n), .cfg(b1),
    .adc_sclk(a1_sclk), .adc_sen(a1_sen), .adc_smosi(a1_mosi), .adc_smiso_i(miso[0]),
    .dac_sclk(d1_sclk), .dac_sen(d1_sen), .dac_smosi(d1_mosi), .dac_smiso_i(miso[1])
  );

  wire [1:0] rdy    = sel ? b1.req_ready : b0.req_ready;
  wire [1:0] rspv   = sel ? b1.rsp_valid : b0.rsp_valid;
  wire [7:0] rspd   = sel ? b1.rsp_data  : b0.rsp_data;
  wire       busy   = sel ? b1.busy      : b0.busy;
  wire [1:0] p_sclk = sel ? {d1_sclk, a1_sclk} : {d0_sclk, a0_sclk};
  wire [1:0] p_sen  = sel ? {d1_sen, a1_sen}   : {d0_sen, a0_sen};
  wire [1:0] p_mosi = sel ? {d1_mosi, a1_mosi} : {d0_mosi, a0_mosi};

  // Slave devices: capture MOSI on SCLK rise, present readback MSB-first, advancing on SCLK fall
  logic [15:0] mon_word [2] = '{16'h0, 16'h0};
  int          mon_rises [2] = '{0, 0};
  int          mon_low [2] = '{0, 0};
  logic [4:0]  m_falls [2] = '{5'd0, 5'd0};
  logic [15:0] resp_word [2] = '{16'h0, 16'h0};
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_sen = 2'b11;
  int          last_rise = -1;
  int          gap_bad = 0;
  int          ovl = 0;
  int          idle_bad = 0;

  assign miso[0] = (m_falls[0] < 5'd16) ? resp_word[0][4'(5'd15 - m_falls[0])] : 1'b0;
  assign miso[1] = (m_falls[1] < 5'd16) ? resp_word[1][4'(5'd15 - m_falls[1])] : 1'b0;

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (prev_sen[k] && !p_sen[k]) begin
        if (last_rise >= 0 && (cyc - last_rise) < (sel ? 2 : 9)) gap_bad <= gap_bad + 1;
        mon_word[k]  <= 16'h0;
        mon_rises[k] <= 0;
        m_falls[k]   <= 5'd0;
        mon_low[k]   <= 1;
      end else begin
        if (!p_sen[k]) mon_low[k] <= mon_low[k] + 1;
        if (p_sclk[k] && !prev_sclk[k]) begin
          mon_word[k]  <= {mon_word[k][14:0], p_mosi[k]};
          mon_rises[k] <= mon_rises[k] + 1;
        end
        if (!p_sclk[k] && prev_sclk[k] && m_falls[k] < 5'd16) m_falls[k] <= m_falls[k] + 5'd1;
      end
      if (!prev_sen[k] && p_sen[k]) last_rise <= cyc;
      if (p_sen[k] && (p_sclk[k] || p_mosi[k])) idle_bad <= idle_bad + 1;
    end
    if (!p_sen[0] && !p_sen[1]) ovl <= ovl + 1;
    prev_sclk <= p_sclk;
    prev_sen  <= p_sen;
  end

  int n_chk = 0;
  int n_err = 0;
  int busy_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: round-robin pointer and the next word per requester
  logic        m_last = 1'b1;
  logic [15:0] cur_word [2];
  logic [15:0] cur_resp [2];
  logic        cur_rd [2];

  task automatic new_req(input int k);
    cur_word[k] = 16'($urandom);
    cur_resp[k] = 16'($urandom);
    cur_rd[k]   = 1'($urandom_range(0, 1));
  endtask

  // Called just after a falling edge; drives requesters in 'mask' until n_acc accepts,
  // then checks every completion against the queued expectations
  task automatic run_arb(input int n_acc, input logic [1:0] mask, input int cd, input int gap);
    int          acc, done, guard, dv, t0;
    int          q_dev [$];
    int          q_t0 [$];
    logic [15:0] q_word [$];
    logic [7:0]  q_rb [$];
    logic [15:0] wd;
    logic [7:0]  rb;
    logic [1:0]  want;
    logic        exp_g;
    acc = 0; done = 0; guard = 0; want = mask;
    v = want; d = {cur_word[1], cur_word[0]}; rd = {cur_rd[1], cur_rd[0]};
    #1;
    while (done < n_acc && guard < 3000) begin
      if (rspv != 2'b00) begin
        if (q_dev.size() == 0) begin
          chk("rsp_unexpected", 32'(rspv), 32'h0);
        end else begin
          dv = q_dev.pop_front(); t0 = q_t0.pop_front();
          wd = q_word.pop_front(); rb = q_rb.pop_front();
          chk("rsp_tag", 32'(rspv), (dv == 1) ? 32'h2 : 32'h1);
          chk("rsp_data", 32'(rspd), 32'(rb));
          chk("mosi_word", 32'(mon_word[dv]), 32'(wd));
          chk("sclk_rises", mon_rises[dv], 32'd16);
          chk("sen_low_cycles", mon_low[dv], 32'(34 * cd));
          chk("rsp_latency", cyc - t0, 32'(1 + 34 * cd + gap));
          if (v != 2'b00) chk("regrant_in_rsp_cycle", 32'(rdy != 2'b00), 32'h1);
          if (busy != (rdy != 2'b00)) busy_bad++;
          done++;
        end
      end else if (q_dev.size() > 0 && !busy) begin
        busy_bad++;
      end
      if (rdy != 2'b00) begin
        dv = rdy[1] ? 1 : 0;
        exp_g = (v == 2'b11) ? ~m_last : v[1];
        chk("grant_index", dv, 32'(exp_g));
        chk("grant_onehot", 32'(rdy), (dv == 1) ? 32'h2 : 32'h1);
        if (!busy) busy_bad++;
        m_last = dv[0];
        q_dev.push_back(dv);
        q_t0.push_back(cyc);
        q_word.push_back(cur_word[dv]);
        q_rb.push_back(cur_rd[dv] ? cur_resp[dv][7:0] : 8'h00);
        resp_word[dv] = cur_resp[dv];
        acc++;
        new_req(dv);
        if (acc >= n_acc) want = 2'b00;
      end
      @(negedge CLK);
      guard++;
      v = want; d = {cur_word[1], cur_word[0]}; rd = {cur_rd[1], cur_rd[0]};
      #1;
    end
    if (guard >= 3000) chk("run_timeout", guard, 32'h0);
    v = 2'b00;
  endtask

  int g;
  int spur;

  initial begin
    new_req(0);
    new_req(1);

    // Reset state
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_rsp_valid", 32'(rspv), 32'h0);
    chk("rst_rsp_data", 32'(rspd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sclk", 32'(p_sclk), 32'h0);
    chk("rst_sen", 32'(p_sen), 32'h3);
    chk("rst_mosi", 32'(p_mosi), 32'h0);
    @(negedge CLK);
    rst_n = 1'b1;

    // ADC write of A55A, no readback
    @(negedge CLK);
    cur_word[0] = 16'hA55A; cur_rd[0] = 1'b0;
    run_arb(1, 2'b01, 4, 8);

    // DAC readback of 00C3
    @(negedge CLK);
    cur_rd[1] = 1'b1; cur_resp[1] = 16'h00C3;
    run_arb(1, 2'b10, 4, 8);

    // Both requesters valid across reset exit: ADC first, then DAC
    rst_n = 1'b0;
    m_last = 1'b1;
    v = 2'b11;
    repeat (3) @(negedge CLK);
    #1;
    chk("ready_held_in_reset", 32'(rdy), 32'h0);
    @(negedge CLK);
    rst_n = 1'b1;
    run_arb(2, 2'b11, 4, 8);

    // Continuous contention alternates
    @(negedge CLK);
    run_arb(6, 2'b11, 4, 8);

    // Reset during SHIFT bit 7
    @(negedge CLK);
    new_req(0);
    v = 2'b01; d = {cur_word[1], cur_word[0]}; rd = 2'b00;
    #1;
    g = 0;
    while (!rdy[0] && g < 50) begin @(negedge CLK); #1; g++; end
    chk("mid_accept", 32'(rdy[0]), 32'h1);
    @(negedge CLK);
    v = 2'b00;
    #1;
    g = 0;
    while (mon_rises[0] < 8 && g < 300) begin @(negedge CLK); #1; g++; end
    chk("reached_bit7", mon_rises[0], 32'd8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sen", 32'(p_sen), 32'h3);
    chk("mid_rst_sclk", 32'(p_sclk), 32'h0);
    chk("mid_rst_mosi", 32'(p_mosi), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    m_last = 1'b1;
    spur = 0;
    repeat (10) begin @(negedge CLK); #1; if (rspv != 2'b00) spur++; end
    @(negedge CLK);
    rst_n = 1'b1;
    repeat (200) begin @(negedge CLK); #1; if (rspv != 2'b00) spur++; end
    chk("no_rsp_after_reset", spur, 32'h0);
    @(negedge CLK);
    cur_rd[0] = 1'b1;
    run_arb(1, 2'b01, 4, 8);

    // Fastest divider and shortest gap
    @(negedge CLK);
    sel = 1'b1;
    m_last = 1'b1;
    @(negedge CLK);
    run_arb(3, 2'b11, 2, 1);
    @(negedge CLK);
    cur_rd[1] = 1'b1; cur_resp[1] = 16'h5A3C;
    run_arb(1, 2'b10, 2, 1);

    repeat (4) @(negedge CLK);
    #1;
    chk("idle_pins", idle_bad, 32'h0);
    chk("sen_overlap", ovl, 32'h0);
    chk("cs_gap", gap_bad, 32'h0);
    chk("busy_window", busy_bad, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
